regfile_multiport: RTL

Parametrised successor to the CPU's 3-read/1-write general register file, used by the multi-cycle datapath's decode and write-back stages.
- Adds configurable data width and depth, and a byte-enabled write.
- Adds optional write-to-read bypass and an optional hard-wired zero register.
- Adds a counter-driven clear sequence, so every entry holds zero after reset or on software request (not only entry 0).

---
 rtl/regfile_multiport_pkg.sv | 31 +++
 rtl/regfile_read_port.sv | 34 +++
 rtl/regfile_multiport.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_multiport_pkg.sv
// Shared types and helpers for the multi-port register file: clear-FSM state
// encoding, depth derivation and the byte-enable merge.
package regfile_multiport_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Upper bound on data width handled by merge_bytes; callers pad and truncate.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: zero-register force, busy mask and write-to-read bypass mux.
module regfile_read_port
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_busy,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_wreg,
  input  logic [DATA_W-1:0] i_wmerged,
  output logic [DATA_W-1:0] o_op
);

  logic is_r0;
  logic hit;

  assign is_r0 = (ZERO_R0 != 0) && (i_addr == '0);
  assign hit   = i_wen && !i_busy && (i_wreg == i_addr) && !is_r0;

  always_comb begin
    o_op = i_rdata;
    if (i_busy || is_r0) begin
      o_op = '0;
    end else if ((BYPASS != 0) && hit) begin
      o_op = i_wmerged;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// 3-read/1-write register file with byte-enabled writes, optional bypass and
// zero register, and a counter-driven clear of every entry.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  output logic                o_busy,
  input  logic [ADDR_W-1:0]   i_addr1,
  input  logic [ADDR_W-1:0]   i_addr2,
  input  logic [ADDR_W-1:0]   i_addr3,
  output logic [DATA_W-1:0]   o_op1,
  output logic [DATA_W-1:0]   o_op2,
  output logic [DATA_W-1:0]   o_op3,
  input  logic                i_wen,
  input  logic [ADDR_W-1:0]   i_wreg,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wbe
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] wr_merged;

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_op   [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy   = (state_q == ST_CLEAR);
  assign o_busy = busy;

  // The merged word serves both the array write and every bypass hit.
  assign wr_merged = DATA_W'(merge_bytes(MAX_DATA_W'(mem_q[i_wreg]),
                                         MAX_DATA_W'(i_wdata),
                                         MAX_BE_W'(i_wbe)));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_wreg;
    mem_wdata = wr_merged;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we = i_wen && !((ZERO_R0 != 0) && (i_wreg == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_addr[0] = i_addr1;
  assign rd_addr[1] = i_addr2;
  assign rd_addr[2] = i_addr3;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS)
    ) u_rp (
      .i_addr   (rd_addr[p]),
      .i_rdata  (mem_q[rd_addr[p]]),
      .i_busy   (busy),
      .i_wen    (i_wen),
      .i_wreg   (i_wreg),
      .i_wmerged(wr_merged),
      .o_op     (rd_op[p])
    );
  end

  assign o_op1 = rd_op[0];
  assign o_op2 = rd_op[1];
  assign o_op3 = rd_op[2];

endmodule
